// File: rtl/sat_addsub_pipe.sv
// Two-stage signed add/subtract with optional saturation.
// Valid/ready on both sides; sticky overflow flag on delivered beats.
module sat_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             ov,
  output logic             sticky_ov,
  input  logic             clr_sticky
);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH:0]   s1_sum_q, s1_sum_d;
  logic             s1_sat_q, s1_sat_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             neg_q, neg_d;
  logic             ov_q, ov_d;
  logic             sticky_q, sticky_d;

  logic             s1_load, s2_load;
  logic             acc, dlv;
  logic [WIDTH:0]   a_x, b_x;
  logic             pos_ov, neg_ov;
  logic [WIDTH-1:0] res;

  assign s2_load  = ~s2_vld_q | out_ready;
  assign s1_load  = ~s1_vld_q | s2_load;
  assign in_ready = s1_load & ~rst;
  assign acc      = in_valid & in_ready;
  assign dlv      = s2_vld_q & out_ready;

  // One extra bit keeps A-MIN exact.
  assign a_x = {in1[WIDTH-1], in1};
  assign b_x = {in2[WIDTH-1], in2};

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_sum_d = s1_sum_q;
    s1_sat_d = s1_sat_q;
    if (s1_load) begin
      s1_vld_d = acc;
      if (acc) begin
        s1_sum_d = op ? (a_x - b_x) : (a_x + b_x);
        s1_sat_d = sat_en;
      end
    end
  end

  assign pos_ov = ~s1_sum_q[WIDTH] &  s1_sum_q[WIDTH-1];
  assign neg_ov =  s1_sum_q[WIDTH] & ~s1_sum_q[WIDTH-1];

  always_comb begin
    res = s1_sum_q[WIDTH-1:0];
    unique case (1'b1)
      s1_sat_q & pos_ov: res = {1'b0, {(WIDTH-1){1'b1}}};
      s1_sat_q & neg_ov: res = {1'b1, {(WIDTH-1){1'b0}}};
      default:           res = s1_sum_q[WIDTH-1:0];
    endcase
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    out_d    = out_q;
    zr_d     = zr_q;
    neg_d    = neg_q;
    ov_d     = ov_q;
    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_d = res;
        zr_d  = (res == '0);
        neg_d = res[WIDTH-1];
        ov_d  = pos_ov | neg_ov;
      end
    end
    // Set beats clear when both happen together.
    sticky_d = (dlv & ov_q) | (sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_sum_q <= '0;
      s1_sat_q <= 1'b0;
      s2_vld_q <= 1'b0;
      out_q    <= '0;
      zr_q     <= 1'b0;
      neg_q    <= 1'b0;
      ov_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_sum_q <= s1_sum_d;
      s1_sat_q <= s1_sat_d;
      s2_vld_q <= s2_vld_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      neg_q    <= neg_d;
      ov_q     <= ov_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign neg       = neg_q;
  assign ov        = ov_q;
  assign sticky_ov = sticky_q;

endmodule
